// File: rtl/approx_mul_arbiter.sv
// Round-robin front end sharing one external 16x16 approximate multiplier core; S1 operand regs, S2 result regs.
// Accept-to-rsp_valid two edges, one result per cycle; a full pipe with rsp_ready low drops req_ready, nothing lost.
module approx_mul_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_p,
  input  logic                  mul_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  err_clr,
  output logic                  busy
);

  // Bit 0 tracks S1 occupancy, bit 1 tracks S2 occupancy.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S1_ONLY = 2'b01,
    S2_ONLY = 2'b10,
    FULL    = 2'b11
  } occ_t;

  occ_t           state, state_nxt;
  logic           s1_valid;
  logic           s2_en;
  logic           s1_free;
  logic           grant_en;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;

  assign s1_valid  = (state == S1_ONLY) || (state == FULL);
  assign rsp_valid = (state == S2_ONLY) || (state == FULL);
  assign busy      = s1_valid | rsp_valid;

  assign s2_en    = s1_valid & (~rsp_valid | rsp_ready);
  assign s1_free  = ~s1_valid | s2_en;
  // Gated by rst so no requester sees an accept while the pipe is held in reset.
  assign grant_en = ~rst & s1_free & (|req_valid);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (grant_en) state_nxt = S1_ONLY;
      // S2 is empty here, so S1 always moves into it.
      S1_ONLY: state_nxt = grant_en ? FULL : S2_ONLY;
      S2_ONLY: begin
        if (grant_en)       state_nxt = rsp_ready ? S1_ONLY : FULL;
        else if (rsp_ready) state_nxt = EMPTY;
      end
      FULL:    if (rsp_ready) state_nxt = grant_en ? FULL : S2_ONLY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      s1_id   <= '0;
      rr_ptr  <= '0;
      rsp_p   <= '0;
      rsp_id  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (grant_en) begin
        mul_a  <= req_a[int'(winner)*WIDTH +: WIDTH];
        mul_b  <= req_b[int'(winner)*WIDTH +: WIDTH];
        s1_id  <= winner;
        rr_ptr <= winner + IDW'(1);
      end
      if (s2_en) begin
        rsp_p   <= mul_p;
        rsp_err <= mul_err;
        rsp_id  <= s1_id;
      end
    end
  end

  // Clear beats a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      err_cnt <= '0;
    else if (err_clr)                             err_cnt <= '0;
    else if (s2_en && mul_err && !(&err_cnt))     err_cnt <= err_cnt + 1'b1;
  end

endmodule
